// File: rtl/shade_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shade_arbiter
// Brief    : Round-robin issue of hit/normal pairs to a shader; a tag FIFO
//            re-attaches {id, addr} to each returned pixel.
// Revision : 1.0 - initial release
// ============================================================================
module shade_arbiter #(
    parameter int SIZE         = 32,
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 17,
    parameter int MAX_INFLIGHT = 64
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_REQ*3*SIZE-1:0]     s_hit_tdata,
    input  logic [NUM_REQ*3*SIZE-1:0]     s_normal_tdata,
    input  logic [NUM_REQ-1:0]            s_is_cylinder,
    input  logic [NUM_REQ*ADDR_W-1:0]     s_addr,
    input  logic [NUM_REQ-1:0]            s_tvalid,
    output logic [NUM_REQ-1:0]            s_tready,
    output logic [3*SIZE-1:0]             hit_point_tdata,
    output logic                          hit_point_tvalid,
    input  logic                          hit_point_tready,
    output logic [3*SIZE-1:0]             normal_tdata,
    output logic                          normal_tvalid,
    input  logic                          normal_tready,
    output logic                          is_cylinder,
    input  logic [23:0]                   shd_pixel_tdata,
    input  logic                          shd_pixel_tvalid,
    output logic                          shd_pixel_tready,
    output logic [23:0]                   m_pixel_tdata,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [$clog2(NUM_REQ)-1:0]    m_id,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          err_orphan
);

    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_sum_w = c_id_w + 1;
    localparam int c_ptr_w = $clog2(MAX_INFLIGHT);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_sum_w-1:0] c_num_req = c_sum_w'(NUM_REQ);
    localparam logic [c_cnt_w-1:0] c_max     = c_cnt_w'(MAX_INFLIGHT);

    logic [3*SIZE-1:0]  w_hit_arr  [NUM_REQ];
    logic [3*SIZE-1:0]  w_nrm_arr  [NUM_REQ];
    logic [ADDR_W-1:0]  w_addr_arr [NUM_REQ];

    logic [3*SIZE-1:0]  r_hit;
    logic [3*SIZE-1:0]  r_normal;
    logic               r_is_cyl;
    logic               r_hit_pend;
    logic               r_nrm_pend;
    logic [c_id_w-1:0]  r_rr_ptr;
    logic               r_err_orphan;

    logic [c_id_w+ADDR_W-1:0] r_tag_mem [MAX_INFLIGHT];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_inflight;

    logic               w_req_any;
    logic [c_id_w-1:0]  w_grant_idx;
    logic [c_sum_w-1:0] w_sum;
    logic [c_id_w-1:0]  w_sel;
    logic [c_id_w-1:0]  w_rr_next;
    logic               w_free;
    logic               w_credit_ok;
    logic               w_grant;
    logic               w_empty;
    logic               w_pop;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_hit_arr[gi]  = s_hit_tdata[gi*3*SIZE +: 3*SIZE];
            assign w_nrm_arr[gi]  = s_normal_tdata[gi*3*SIZE +: 3*SIZE];
            assign w_addr_arr[gi] = s_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Scan from the highest offset down so the requester nearest r_rr_ptr wins.
    always_comb begin
        w_req_any   = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_sel       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + c_sum_w'(k);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            w_sel = w_sum[c_id_w-1:0];
            if (s_tvalid[w_sel]) begin
                w_req_any   = 1'b1;
                w_grant_idx = w_sel;
            end
        end
    end

    // Issue slot is reusable when every pending channel completes this cycle.
    assign w_free      = (~r_hit_pend | hit_point_tready) & (~r_nrm_pend | normal_tready);
    assign w_credit_ok = (r_inflight < c_max);
    assign w_grant     = aresetn & w_req_any & w_free & w_credit_ok;
    assign w_rr_next   = (w_grant_idx == c_id_w'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        s_tready = '0;
        if (w_grant) begin
            s_tready[w_grant_idx] = 1'b1;
        end
    end

    assign hit_point_tdata  = r_hit;
    assign hit_point_tvalid = r_hit_pend;
    assign normal_tdata     = r_normal;
    assign normal_tvalid    = r_nrm_pend;
    assign is_cylinder      = r_is_cyl;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hit      <= '0;
            r_normal   <= '0;
            r_is_cyl   <= 1'b0;
            r_hit_pend <= 1'b0;
            r_nrm_pend <= 1'b0;
            r_rr_ptr   <= '0;
        end else if (w_grant) begin
            r_hit      <= w_hit_arr[w_grant_idx];
            r_normal   <= w_nrm_arr[w_grant_idx];
            r_is_cyl   <= s_is_cylinder[w_grant_idx];
            r_hit_pend <= 1'b1;
            r_nrm_pend <= 1'b1;
            r_rr_ptr   <= w_rr_next;
        end else begin
            if (hit_point_tready) begin
                r_hit_pend <= 1'b0;
            end
            if (normal_tready) begin
                r_nrm_pend <= 1'b0;
            end
        end
    end

    assign w_empty          = (r_inflight == '0);
    assign w_pop            = shd_pixel_tvalid & m_tready & ~w_empty;
    assign m_tvalid         = shd_pixel_tvalid;
    assign shd_pixel_tready = m_tready;
    assign m_pixel_tdata    = shd_pixel_tdata;
    assign {m_id, m_addr}   = r_tag_mem[r_rd_ptr];
    assign err_orphan       = r_err_orphan;

    always_ff @(posedge aclk) begin
        if (w_grant) begin
            r_tag_mem[r_wr_ptr] <= {w_grant_idx, w_addr_arr[w_grant_idx]};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_inflight   <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_grant) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            if (shd_pixel_tvalid && w_empty) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shade_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shade_arbiter
// Brief    : Directed self-checking bench for shade_arbiter (2 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shade_arbiter;

    localparam int SIZE         = 32;
    localparam int NUM_REQ      = 2;
    localparam int ADDR_W       = 17;
    localparam int MAX_INFLIGHT = 64;

    logic                      aclk = 1'b0;
    logic                      aresetn = 1'b1;
    logic [NUM_REQ*3*SIZE-1:0] s_hit_tdata;
    logic [NUM_REQ*3*SIZE-1:0] s_normal_tdata;
    logic [NUM_REQ-1:0]        s_is_cylinder;
    logic [NUM_REQ*ADDR_W-1:0] s_addr;
    logic [NUM_REQ-1:0]        s_tvalid;
    logic [NUM_REQ-1:0]        s_tready;
    logic [3*SIZE-1:0]         hit_point_tdata;
    logic                      hit_point_tvalid;
    logic                      hit_point_tready;
    logic [3*SIZE-1:0]         normal_tdata;
    logic                      normal_tvalid;
    logic                      normal_tready;
    logic                      is_cylinder;
    logic [23:0]               shd_pixel_tdata;
    logic                      shd_pixel_tvalid;
    logic                      shd_pixel_tready;
    logic [23:0]               m_pixel_tdata;
    logic [ADDR_W-1:0]         m_addr;
    logic [0:0]                m_id;
    logic                      m_tvalid;
    logic                      m_tready;
    logic                      err_orphan;

    int checks   = 0;
    int failures = 0;
    int gcount;

    logic [1:0]        exp_gnt  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [0:0]        exp_id   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [ADDR_W-1:0] exp_addr [4] = '{17'd100, 17'd201, 17'd102, 17'd203};
    logic              exp_hv   [3] = '{1'b1, 1'b0, 1'b0};

    shade_arbiter #(
        .SIZE(SIZE), .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_hit_tdata(s_hit_tdata), .s_normal_tdata(s_normal_tdata),
        .s_is_cylinder(s_is_cylinder), .s_addr(s_addr),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .hit_point_tdata(hit_point_tdata), .hit_point_tvalid(hit_point_tvalid),
        .hit_point_tready(hit_point_tready),
        .normal_tdata(normal_tdata), .normal_tvalid(normal_tvalid),
        .normal_tready(normal_tready), .is_cylinder(is_cylinder),
        .shd_pixel_tdata(shd_pixel_tdata), .shd_pixel_tvalid(shd_pixel_tvalid),
        .shd_pixel_tready(shd_pixel_tready),
        .m_pixel_tdata(m_pixel_tdata), .m_addr(m_addr), .m_id(m_id),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .err_orphan(err_orphan)
    );

    always #5 aclk = ~aclk;

    function automatic logic [95:0] hit_of(input int i);
        return {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h3000_0000 + 32'(i)};
    endfunction

    function automatic logic [95:0] nrm_of(input int i);
        return {32'h4000_0000 + 32'(i), 32'h5000_0000 + 32'(i), 32'h6000_0000 + 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        s_hit_tdata      = {hit_of(1), hit_of(0)};
        s_normal_tdata   = {nrm_of(1), nrm_of(0)};
        s_is_cylinder    = 2'b10;
        s_addr           = '0;
        s_tvalid         = 2'b11;
        hit_point_tready = 1'b1;
        normal_tready    = 1'b1;
        shd_pixel_tdata  = '0;
        shd_pixel_tvalid = 1'b0;
        m_tready         = 1'b1;

        // Reset state
        #1 aresetn = 1'b0;
        #1;
        chk("rst_tready", s_tready, 2'b00);
        chk("rst_hit_valid", hit_point_tvalid, 1'b0);
        chk("rst_nrm_valid", normal_tvalid, 1'b0);
        chk("rst_err", err_orphan, 1'b0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;

        // Contention: round-robin 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            s_addr = {17'(200 + k), 17'(100 + k)};
            #1;
            chk("contend_gnt", s_tready, exp_gnt[k]);
            tick();
        end
        s_tvalid = 2'b00;
        #1;
        chk("contend_last_hit_v", hit_point_tvalid, 1'b1);
        chk("contend_last_hit_d", hit_point_tdata, hit_of(1));
        tick();
        shd_pixel_tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            shd_pixel_tdata = 24'h000100 + 24'(k);
            #1;
            chk("contend_m_id", m_id, exp_id[k]);
            chk("contend_m_addr", m_addr, exp_addr[k]);
            chk("contend_m_pix", m_pixel_tdata, 24'h000100 + 24'(k));
            tick();
        end
        shd_pixel_tvalid = 1'b0;

        // Single request
        s_addr   = {17'h00000, 17'h1ABCD};
        s_tvalid = 2'b01;
        #1;
        chk("single_gnt", s_tready, 2'b01);
        tick();
        s_tvalid = 2'b00;
        #1;
        chk("single_hit_v", hit_point_tvalid, 1'b1);
        chk("single_nrm_v", normal_tvalid, 1'b1);
        chk("single_hit_d", hit_point_tdata, hit_of(0));
        chk("single_nrm_d", normal_tdata, nrm_of(0));
        chk("single_cyl", is_cylinder, 1'b0);
        tick();
        chk("single_hit_v_drop", hit_point_tvalid, 1'b0);
        chk("single_nrm_v_drop", normal_tvalid, 1'b0);
        shd_pixel_tvalid = 1'b1;
        shd_pixel_tdata  = 24'hABCDEF;
        #1;
        chk("single_m_valid", m_tvalid, 1'b1);
        chk("single_shd_ready", shd_pixel_tready, 1'b1);
        chk("single_m_id", m_id, 1'b0);
        chk("single_m_addr", m_addr, 17'h1ABCD);
        tick();
        shd_pixel_tvalid = 1'b0;

        // Split accept: normal channel held off for 3 cycles
        normal_tready = 1'b0;
        s_addr   = {17'h00222, 17'h00111};
        s_tvalid = 2'b01;
        #1;
        chk("split_gnt0", s_tready, 2'b01);
        tick();
        s_tvalid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("split_hit_v", hit_point_tvalid, exp_hv[c]);
            chk("split_nrm_v", normal_tvalid, 1'b1);
            chk("split_no_gnt", s_tready, 2'b00);
            tick();
        end
        normal_tready = 1'b1;
        #1;
        chk("split_nrm_v4", normal_tvalid, 1'b1);
        chk("split_gnt1", s_tready, 2'b10);
        tick();
        s_tvalid = 2'b00;
        #1;
        chk("split_hit_d1", hit_point_tdata, hit_of(1));
        chk("split_cyl1", is_cylinder, 1'b1);
        tick();
        shd_pixel_tvalid = 1'b1;
        #1;
        chk("split_m_id0", m_id, 1'b0);
        chk("split_m_addr0", m_addr, 17'h00111);
        tick();
        chk("split_m_id1", m_id, 1'b1);
        chk("split_m_addr1", m_addr, 17'h00222);
        tick();
        shd_pixel_tvalid = 1'b0;

        // Back-pressure, then orphan pixel
        s_addr   = {17'h00000, 17'h00333};
        s_tvalid = 2'b01;
        #1;
        chk("bp_gnt", s_tready, 2'b01);
        tick();
        s_tvalid         = 2'b00;
        m_tready         = 1'b0;
        shd_pixel_tvalid = 1'b1;
        shd_pixel_tdata  = 24'h555555;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_shd_ready", shd_pixel_tready, 1'b0);
            chk("bp_m_valid", m_tvalid, 1'b1);
            chk("bp_m_addr", m_addr, 17'h00333);
            chk("bp_err", err_orphan, 1'b0);
            tick();
        end
        m_tready = 1'b1;
        #1;
        chk("bp_release_ready", shd_pixel_tready, 1'b1);
        chk("bp_release_addr", m_addr, 17'h00333);
        tick();
        chk("orphan_not_yet", err_orphan, 1'b0);
        tick();
        shd_pixel_tvalid = 1'b0;
        chk("orphan_set", err_orphan, 1'b1);
        tick();
        chk("orphan_sticky", err_orphan, 1'b1);

        // Credit limit
        s_tvalid = 2'b01;
        gcount   = 0;
        for (int k = 0; k < 64; k++) begin
            s_addr = {17'h00000, 17'(k)};
            #1;
            if (s_tready[0]) gcount++;
            tick();
        end
        chk("credit_grants", gcount, 64);
        #1;
        chk("credit_block", s_tready, 2'b00);
        tick();
        chk("credit_block2", s_tready, 2'b00);
        shd_pixel_tvalid = 1'b1;
        #1;
        chk("credit_pop_addr", m_addr, 17'd0);
        chk("credit_pop_cycle", s_tready, 2'b00);
        tick();
        shd_pixel_tvalid = 1'b0;
        s_addr = {17'h00000, 17'd64};
        #1;
        chk("credit_one_gnt", s_tready, 2'b01);
        tick();
        chk("credit_block3", s_tready, 2'b00);

        // Drain down to 10 in flight, checking FIFO order
        s_tvalid         = 2'b00;
        shd_pixel_tvalid = 1'b1;
        for (int k = 1; k <= 54; k++) begin
            #1;
            chk("drain_addr", m_addr, 17'(k));
            tick();
        end
        shd_pixel_tvalid = 1'b0;

        // Mid-operation reset
        normal_tready = 1'b0;
        s_tvalid      = 2'b01;
        #1;
        chk("mrst_gnt", s_tready, 2'b01);
        tick();
        s_tvalid = 2'b11;
        #1;
        chk("mrst_nrm_pend", normal_tvalid, 1'b1);
        chk("mrst_blocked", s_tready, 2'b00);
        #1 aresetn = 1'b0;
        #1;
        chk("mrst_hit_v", hit_point_tvalid, 1'b0);
        chk("mrst_nrm_v", normal_tvalid, 1'b0);
        chk("mrst_tready", s_tready, 2'b00);
        chk("mrst_err", err_orphan, 1'b0);
        tick();
        tick();
        aresetn          = 1'b1;
        s_tvalid         = 2'b00;
        shd_pixel_tvalid = 1'b1;
        m_tready         = 1'b1;
        tick();
        chk("mrst_fifo_empty", err_orphan, 1'b1);
        shd_pixel_tvalid = 1'b0;
        normal_tready    = 1'b1;
        s_addr           = {17'h00BBB, 17'h00AAA};
        s_tvalid         = 2'b11;
        #1;
        chk("mrst_first_gnt", s_tready, 2'b01);
        tick();
        s_tvalid         = 2'b00;
        shd_pixel_tvalid = 1'b1;
        #1;
        chk("mrst_m_id", m_id, 1'b0);
        chk("mrst_m_addr", m_addr, 17'h00AAA);
        tick();
        shd_pixel_tvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
